// File: rtl/hms_time_counter.sv
// BCD 24 h time-of-day core: 1 s prescaler, HH:MM:SS BCD counters with per-field
// set/adjust from six active-low debounced keys, including hold-to-repeat.
module hms_time_counter #(
  parameter int TICK_DIV   = 50000000,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_key_state,
  input  logic       i_run,
  output logic [7:0] o_hh_bcd,
  output logic [7:0] o_mm_bcd,
  output logic [7:0] o_ss_bcd,
  output logic       o_sec_tick,
  output logic       o_day_wrap,
  output logic       o_adj_active
);

  localparam int PW      = $clog2(TICK_DIV);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [RW-1:0] DLY_C    = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] PER_C    = RW'(REPEAT_PER);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == top)              r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] r;
    if (v == 8'h00)            r = top;
    else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
    else                       r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_adj(input logic [7:0] v, input logic [7:0] top,
                                         input logic up, input logic dn);
    logic [7:0] r;
    if (up && !dn)      r = bcd_inc(v, top);
    else if (dn && !up) r = bcd_dec(v, top);
    else                r = v;
    return r;
  endfunction

  logic [5:0]    key_prev;
  logic [5:0]    key_armed;
  logic [5:0]    held_prev;
  logic [RW-1:0] rep_cnt;
  logic          rep_ph;
  logic [PW-1:0] pre;

  logic [5:0] held;
  logic [5:0] press;
  logic [5:0] step;
  logic       held_chg;
  logic       one_held;
  logic       rep_fire;
  logic       adj_any;
  logic       pre_wrap;
  logic       tick;
  logic [7:0] hh_n, mm_n, ss_n;
  logic       wrap_n;

  // A key only becomes armed once it has been seen released, so a key held
  // through reset release neither presses nor auto-repeats.
  assign held     = ~i_key_state & key_armed;
  assign press    = key_prev & ~i_key_state & key_armed;
  assign held_chg = (held != held_prev);
  assign one_held = (held != 6'd0) && ((held & (held - 6'd1)) == 6'd0);
  assign rep_fire = one_held && !held_chg && (rep_cnt == (rep_ph ? PER_C : DLY_C));
  assign step     = press | (rep_fire ? held : 6'd0);
  assign adj_any  = |step;
  assign pre_wrap = (pre == PRE_LAST);
  assign tick     = i_run && pre_wrap && !adj_any;

  always_comb begin
    hh_n   = o_hh_bcd;
    mm_n   = o_mm_bcd;
    ss_n   = o_ss_bcd;
    wrap_n = 1'b0;
    if (tick) begin
      ss_n = bcd_inc(o_ss_bcd, 8'h59);
      if (o_ss_bcd == 8'h59) begin
        mm_n = bcd_inc(o_mm_bcd, 8'h59);
        if (o_mm_bcd == 8'h59) begin
          hh_n = bcd_inc(o_hh_bcd, 8'h23);
          wrap_n = (o_hh_bcd == 8'h23);
        end
      end
    end else begin
      ss_n = bcd_adj(o_ss_bcd, 8'h59, step[1], step[0]);
      mm_n = bcd_adj(o_mm_bcd, 8'h59, step[3], step[2]);
      hh_n = bcd_adj(o_hh_bcd, 8'h23, step[5], step[4]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hh_bcd     <= 8'h00;
      o_mm_bcd     <= 8'h00;
      o_ss_bcd     <= 8'h00;
      o_sec_tick   <= 1'b0;
      o_day_wrap   <= 1'b0;
      o_adj_active <= 1'b0;
      pre          <= '0;
      key_prev     <= 6'h3f;
      key_armed    <= 6'h00;
      held_prev    <= 6'h00;
      rep_cnt      <= '0;
      rep_ph       <= 1'b0;
    end else begin
      o_hh_bcd     <= hh_n;
      o_mm_bcd     <= mm_n;
      o_ss_bcd     <= ss_n;
      o_sec_tick   <= tick;
      o_day_wrap   <= wrap_n;
      o_adj_active <= ~&i_key_state;
      key_prev     <= i_key_state;
      key_armed    <= key_armed | i_key_state;
      held_prev    <= held;

      if (!i_run || adj_any || pre_wrap) pre <= '0;
      else                               pre <= pre + PRE_ONE;

      // rep_ph: 0 = waiting out the initial hold delay, 1 = repeating.
      if (held_chg) begin
        rep_cnt <= one_held ? REP_ONE : '0;
        rep_ph  <= 1'b0;
      end else if (!one_held) begin
        rep_cnt <= '0;
        rep_ph  <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt <= REP_ONE;
        rep_ph  <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + REP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hms_time_counter.sv
// Directed bench for hms_time_counter at TICK_DIV=10, REPEAT_DLY=20, REPEAT_PER=5.
module tb_hms_time_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] keys = 6'h3f;
  logic       run = 1'b1;
  logic [7:0] hh, mm, ss;
  logic       sec_tick, day_wrap, adj_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  keys;
    logic [23:0] exp_time;
  } vec_t;

  vec_t vecs[20];

  hms_time_counter #(
    .TICK_DIV  (10),
    .REPEAT_DLY(20),
    .REPEAT_PER(5)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_state (keys),
    .i_run       (run),
    .o_hh_bcd    (hh),
    .o_mm_bcd    (mm),
    .o_ss_bcd    (ss),
    .o_sec_tick  (sec_tick),
    .o_day_wrap  (day_wrap),
    .o_adj_active(adj_active)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_h;

    vecs[0]  = '{6'b111101, 24'h000001};
    vecs[1]  = '{6'b111110, 24'h000000};
    vecs[2]  = '{6'b111110, 24'h000059};
    vecs[3]  = '{6'b111101, 24'h000000};
    vecs[4]  = '{6'b111011, 24'h005900};
    vecs[5]  = '{6'b111011, 24'h005800};
    vecs[6]  = '{6'b110111, 24'h005900};
    vecs[7]  = '{6'b110111, 24'h000000};
    vecs[8]  = '{6'b110111, 24'h000100};
    vecs[9]  = '{6'b101111, 24'h230100};
    vecs[10] = '{6'b011111, 24'h000100};
    vecs[11] = '{6'b001111, 24'h000100};
    vecs[12] = '{6'b110110, 24'h000259};
    vecs[13] = '{6'b010101, 24'h010300};
    vecs[14] = '{6'b101111, 24'h000300};
    vecs[15] = '{6'b101010, 24'h230259};
    vecs[16] = '{6'b111110, 24'h230258};
    vecs[17] = '{6'b111011, 24'h230158};
    vecs[18] = '{6'b111011, 24'h230058};
    vecs[19] = '{6'b111011, 24'h235958};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_time", {hh, mm, ss}, 24'h000000);
    check("reset_tick", sec_tick, 1'b0);
    check("reset_wrap", day_wrap, 1'b0);
    check("reset_adj", adj_active, 1'b0);
    rst_n = 1'b1;

    // Free run: tick every 10 cycles, seconds count up through 09 -> 10.
    for (int n = 1; n <= 125; n++) begin
      cyc();
      check("run_tick", sec_tick, (n % 10 == 0));
      check("run_wrap", day_wrap, 1'b0);
      if (n % 10 == 0) check("run_time", {hh, mm, ss}, {16'h0000, to_bcd(n / 10)});
    end

    // Asynchronous reset between clock edges, with ss+ held through release.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    keys  = 6'b111101;
    run   = 1'b0;
    #1;
    check("async_rst_time", {hh, mm, ss}, 24'h000000);
    check("async_rst_tick", sec_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) cyc();
    check("held_rst_time", {hh, mm, ss}, 24'h000000);
    check("held_rst_adj", adj_active, 1'b1);
    keys = 6'h3f;
    cyc();
    check("held_rst_release", {hh, mm, ss}, 24'h000000);
    keys = 6'b111101;
    cyc();
    check("held_rst_repress", {hh, mm, ss}, 24'h000001);
    keys = 6'b111110;
    cyc();
    keys = 6'h3f;
    cyc();
    check("held_rst_back", {hh, mm, ss}, 24'h000000);

    // Single-cycle key pulses with the clock frozen.
    for (int i = 0; i < 20; i++) begin
      keys = vecs[i].keys;
      cyc();
      check($sformatf("vec%0d_time", i), {hh, mm, ss}, vecs[i].exp_time);
      check($sformatf("vec%0d_adj", i), adj_active, 1'b1);
      keys = 6'h3f;
      cyc();
      check($sformatf("vec%0d_adj_off", i), adj_active, 1'b0);
    end

    // Day wrap, then an ss+ press landing on the tick cycle.
    run = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      cyc();
      check("wrap_tick", sec_tick, (n == 10 || n == 20 || n == 40));
      check("wrap_flag", day_wrap, (n == 20));
      if (n == 10) check("wrap_t10", {hh, mm, ss}, 24'h235959);
      if (n == 20) check("wrap_t20", {hh, mm, ss}, 24'h000000);
      if (n == 30) check("collide_t30", {hh, mm, ss}, 24'h000001);
      if (n == 40) check("collide_t40", {hh, mm, ss}, 24'h000002);
      if (n == 29) keys = 6'b111101;
      if (n == 30) keys = 6'h3f;
    end

    // Pause mid-second.
    run = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      cyc();
      check("pause_tick", sec_tick, 1'b0);
    end
    check("pause_time", {hh, mm, ss}, 24'h000002);
    run = 1'b1;
    for (int m = 1; m <= 15; m++) begin
      cyc();
      check("resume_tick", sec_tick, (m == 10));
      if (m == 10) check("resume_time", {hh, mm, ss}, 24'h000003);
    end

    // Auto-repeat on hh+ held 40 cycles.
    run  = 1'b0;
    keys = 6'b011111;
    for (int k = 0; k <= 40; k++) begin
      cyc();
      exp_h = 1 + ((k >= 20) ? 1 + (k - 20) / 5 : 0);
      check("repeat_hh", hh, to_bcd(exp_h));
    end
    keys = 6'h3f;
    repeat (10) cyc();
    check("repeat_end", {hh, mm, ss}, 24'h060003);

    // Second key while repeating stops the repeat.
    keys = 6'b011111;
    for (int k = 0; k <= 45; k++) begin
      cyc();
      exp_h = 7 + ((k >= 20) ? 1 : 0);
      check("stop_hh", hh, to_bcd(exp_h));
      check("stop_mm", mm, (k >= 22) ? 8'h01 : 8'h00);
      if (k == 21) keys = 6'b010111;
    end
    keys = 6'h3f;
    repeat (5) cyc();
    check("stop_end", {hh, mm, ss}, 24'h080103);
    check("stop_adj_off", adj_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
